// File: rtl/ov_frame_streamer_if.sv
// Byte-stream handshake between the frame streamer and its sink.
`default_nettype none

interface ov_frame_streamer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;

  modport master (output out_valid, out_data, out_sof, out_eol, input out_ready);
  modport slave  (input out_valid, out_data, out_sof, out_eol, output out_ready);
endinterface

`default_nettype wire

// File: rtl/ov_frame_streamer.sv
// Drains one camera frame from an AL422-style FIFO into a paced byte stream,
// optionally inserting CR,LF terminators per line or per frame.
`default_nettype none

module ov_frame_streamer #(
  parameter int H_PIXELS      = 320,
  parameter int V_LINES       = 240,
  parameter int BYTES_PER_PIX = 2,
  parameter int GAP_CYCLES    = 2500,
  parameter int EOL_MODE      = 1
) (
  input  wire logic            clk_25MHz,
  input  wire logic            rst_n,
  input  wire logic            initialized,
  input  wire logic            new_frame,
  input  wire logic            abort,
  input  wire logic [7:0]      fifo_data,
  output logic                 fifo_rclk,
  output logic                 fifo_rrst,
  output logic                 frame_read,
  ov_frame_streamer_if.master  stream,
  output logic [15:0]          frame_count
);

  localparam int LINE_BYTES = H_PIXELS * BYTES_PER_PIX;
  localparam int BYTE_W     = $clog2(LINE_BYTES + 1);
  localparam int LINE_W     = $clog2(V_LINES + 1);
  localparam int GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BYTE_W-1:0] LINE_BYTES_C = BYTE_W'(LINE_BYTES);
  localparam logic [LINE_W-1:0] V_LINES_C    = LINE_W'(V_LINES);
  localparam logic [GAP_W-1:0]  GAP_C        = GAP_W'(GAP_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_R1, S_R2, S_R3, S_R4, S_R5, S_R6,
    S_RD_LO, S_LATCH, S_HOLD, S_GAP, S_TERM, S_THOLD, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [BYTE_W-1:0]   byte_cnt, byte_nx;
  logic [LINE_W-1:0]   line_cnt, line_nx;
  logic [GAP_W-1:0]    gap_cnt, gap_nx;
  logic                term_lf, term_nx;
  logic                rclk_q, rclk_nx;
  logic                rrst_q, rrst_nx;
  logic                fr_q, fr_nx;
  logic                valid_q, valid_nx;
  logic [7:0]          data_q, data_nx;
  logic                sof_q, sof_nx;
  logic                eol_q, eol_nx;
  logic [15:0]         count_q, count_nx;
  logic                at_eol, at_eof;

  // Where to go once a gap (or a zero-length gap) has elapsed: a pending LF
  // wins, then the frame ends once every line has been consumed.
  function automatic state_t resume(input logic lf_pending, input logic [LINE_W-1:0] lines);
    if (lf_pending)
      return S_TERM;
    else if (lines == '0)
      return S_DONE;
    else
      return S_RD_LO;
  endfunction

  assign at_eol = (byte_cnt == BYTE_W'(1));
  assign at_eof = at_eol && (line_cnt == LINE_W'(1));

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      line_cnt <= '0;
      gap_cnt  <= '0;
      term_lf  <= 1'b0;
      rclk_q   <= 1'b1;
      rrst_q   <= 1'b1;
      fr_q     <= 1'b1;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state    <= state_nx;
      byte_cnt <= byte_nx;
      line_cnt <= line_nx;
      gap_cnt  <= gap_nx;
      term_lf  <= term_nx;
      rclk_q   <= rclk_nx;
      rrst_q   <= rrst_nx;
      fr_q     <= fr_nx;
      valid_q  <= valid_nx;
      data_q   <= data_nx;
      sof_q    <= sof_nx;
      eol_q    <= eol_nx;
      count_q  <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    byte_nx  = byte_cnt;
    line_nx  = line_cnt;
    gap_nx   = gap_cnt;
    term_nx  = term_lf;
    rclk_nx  = rclk_q;
    rrst_nx  = rrst_q;
    fr_nx    = fr_q;
    valid_nx = valid_q;
    data_nx  = data_q;
    sof_nx   = sof_q;
    eol_nx   = eol_q;
    count_nx = count_q;

    if (abort && (state != S_IDLE)) begin
      // Abort beats a same-edge handshake, so a presented byte is dropped.
      state_nx = S_IDLE;
      valid_nx = 1'b0;
      rclk_nx  = 1'b1;
      rrst_nx  = 1'b1;
      fr_nx    = 1'b1;
      sof_nx   = 1'b0;
      eol_nx   = 1'b0;
    end else if (initialized) begin
      case (state)
        S_IDLE: begin
          if (new_frame) begin
            fr_nx    = 1'b0;
            byte_nx  = LINE_BYTES_C;
            line_nx  = V_LINES_C;
            gap_nx   = '0;
            term_nx  = 1'b0;
            state_nx = S_R1;
          end
        end
        // Read-pointer reset: one rclk pulse while rrst is low, then the
        // first rising edge with rrst high presents byte 0 on fifo_data.
        S_R1: begin rrst_nx = 1'b0; state_nx = S_R2; end
        S_R2: begin rclk_nx = 1'b0; state_nx = S_R3; end
        S_R3: begin rclk_nx = 1'b1; state_nx = S_R4; end
        S_R4: begin rclk_nx = 1'b0; state_nx = S_R5; end
        S_R5: begin rrst_nx = 1'b1; state_nx = S_R6; end
        S_R6: begin rclk_nx = 1'b1; state_nx = S_RD_LO; end
        S_RD_LO: begin
          rclk_nx  = 1'b0;
          state_nx = S_LATCH;
        end
        S_LATCH: begin
          data_nx  = fifo_data;
          valid_nx = 1'b1;
          sof_nx   = (byte_cnt == LINE_BYTES_C) && (line_cnt == V_LINES_C);
          eol_nx   = at_eol;
          state_nx = S_HOLD;
        end
        S_HOLD: begin
          if (stream.out_ready) begin
            valid_nx = 1'b0;
            rclk_nx  = 1'b1;
            gap_nx   = GAP_C;
            if (at_eol) begin
              byte_nx = LINE_BYTES_C;
              line_nx = line_cnt - LINE_W'(1);
            end else begin
              byte_nx = byte_cnt - BYTE_W'(1);
            end
            if ((at_eol && (EOL_MODE == 2)) || (at_eof && (EOL_MODE == 1)))
              state_nx = S_TERM;
            else if (at_eof)
              state_nx = S_DONE;
            else if (GAP_CYCLES == 0)
              state_nx = S_RD_LO;
            else
              state_nx = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt > GAP_W'(1)) begin
            gap_nx = gap_cnt - GAP_W'(1);
          end else begin
            gap_nx   = '0;
            state_nx = resume(term_lf, line_cnt);
          end
        end
        S_TERM: begin
          data_nx  = term_lf ? 8'h0A : 8'h0D;
          valid_nx = 1'b1;
          sof_nx   = 1'b0;
          eol_nx   = 1'b0;
          state_nx = S_THOLD;
        end
        S_THOLD: begin
          if (stream.out_ready) begin
            valid_nx = 1'b0;
            gap_nx   = GAP_C;
            term_nx  = !term_lf;
            state_nx = (GAP_CYCLES == 0) ? resume(!term_lf, line_cnt) : S_GAP;
          end
        end
        S_DONE: begin
          fr_nx    = 1'b1;
          count_nx = count_q + 16'd1;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign fifo_rclk        = rclk_q;
  assign fifo_rrst        = rrst_q;
  assign frame_read       = fr_q;
  assign frame_count      = count_q;
  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_sof   = sof_q;
  assign stream.out_eol   = eol_q;

endmodule

`default_nettype wire

// File: tb/tb_ov_frame_streamer.sv
// Two streamer instances (per-line CR/LF with no gap; per-frame CR/LF with a
// 5-clock gap) checked against a frame-level stream model.
`default_nettype none

module tb_ov_frame_streamer;

  localparam int A_H = 2, A_V = 2, A_BPP = 1, A_GAP = 0, A_EOL = 2;
  localparam int B_H = 3, B_V = 2, B_BPP = 2, B_GAP = 5, B_EOL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic initialized = 1'b1;
  logic nf_a = 1'b0, nf_b = 1'b0, abort_a = 1'b0, abort_b = 1'b0;
  logic [7:0] fd_a, fd_b;
  logic rclk_a, rrst_a, fr_a, rclk_b, rrst_b, fr_b;
  logic [15:0] fc_a, fc_b;

  ov_frame_streamer_if sa();
  ov_frame_streamer_if sb();

  ov_frame_streamer #(.H_PIXELS(A_H), .V_LINES(A_V), .BYTES_PER_PIX(A_BPP),
                      .GAP_CYCLES(A_GAP), .EOL_MODE(A_EOL)) dut_a (
    .clk_25MHz(clk), .rst_n(rst_n), .initialized(initialized), .new_frame(nf_a),
    .abort(abort_a), .fifo_data(fd_a), .fifo_rclk(rclk_a), .fifo_rrst(rrst_a),
    .frame_read(fr_a), .stream(sa), .frame_count(fc_a));

  ov_frame_streamer #(.H_PIXELS(B_H), .V_LINES(B_V), .BYTES_PER_PIX(B_BPP),
                      .GAP_CYCLES(B_GAP), .EOL_MODE(B_EOL)) dut_b (
    .clk_25MHz(clk), .rst_n(rst_n), .initialized(initialized), .new_frame(nf_b),
    .abort(abort_b), .fifo_data(fd_b), .fifo_rclk(rclk_b), .fifo_rrst(rrst_b),
    .frame_read(fr_b), .stream(sb), .frame_count(fc_b));

  always #20 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a rise with rrst low parks the pointer before byte 0,
  // each rise with rrst high advances it.
  int ptr_a = 0, ptr_b = 0, rises_a = 0, rises_b = 0;
  always @(posedge rclk_a) if (rst_n) begin
    if (!rrst_a) ptr_a <= -1;
    else begin ptr_a <= ptr_a + 1; rises_a <= rises_a + 1; end
  end
  always @(posedge rclk_b) if (rst_n) begin
    if (!rrst_b) ptr_b <= -1;
    else begin ptr_b <= ptr_b + 1; rises_b <= rises_b + 1; end
  end
  assign fd_a = 8'h10 + ptr_a[7:0];
  assign fd_b = 8'h40 + ptr_b[7:0];

  logic [9:0] q_a[$], q_b[$], log_a[$];
  int   acc_edge[2], acc_n[2];
  logic pv_hold[2], pv_v[2];
  logic [9:0] pv_word[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [9:0] w);
    if (i == 0) q_a.push_back(w); else q_b.push_back(w);
  endtask

  // Expected frame: bytes in FIFO order, sof on the first, eol on each line's
  // last byte, CR,LF after every line (mode 2) or after the frame (mode 1).
  task automatic load_frame(input int i);
    int lb, nl, mode;
    logic [7:0] base;
    lb   = (i == 0) ? A_H * A_BPP : B_H * B_BPP;
    nl   = (i == 0) ? A_V : B_V;
    mode = (i == 0) ? A_EOL : B_EOL;
    base = (i == 0) ? 8'h10 : 8'h40;
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < lb; b++)
        push(i, {(l == 0 && b == 0), (b == lb - 1), 8'(int'(base) + l * lb + b)});
      if (mode == 2 || (mode == 1 && l == nl - 1)) begin
        push(i, {2'b00, 8'h0D});
        push(i, {2'b00, 8'h0A});
      end
    end
  endtask

  task automatic mon(input int i, input logic v, input logic r, input logic [7:0] d,
                     input logic s, input logic e, input logic ab);
    logic [9:0] w, x;
    logic have;
    int gp, sp;
    w  = {s, e, d};
    gp = (i == 0) ? A_GAP : B_GAP;
    if (!rst_n) begin
      pv_hold[i] = 1'b0;
      pv_v[i]    = 1'b0;
      return;
    end
    if (pv_hold[i])
      chk("hold_stable", {21'b0, v, w}, {21'b0, 1'b1, pv_word[i]});
    if (v && !pv_v[i] && acc_edge[i] >= 0 && !s) begin
      sp = cyc - acc_edge[i];
      chk("valid_spacing", sp, (d == 8'h0D) ? 1 : (d == 8'h0A) ? gp + 1 : gp + 2);
    end
    if (v && r && !ab) begin
      have = (i == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
      chk("stream_expected", {31'b0, have}, 1);
      if (have) begin
        if (i == 0) x = q_a.pop_front(); else x = q_b.pop_front();
        chk("stream_byte", {22'b0, w}, {22'b0, x});
      end
      if (i == 0) log_a.push_back(w);
      acc_edge[i] = cyc + 1;
      acc_n[i]++;
    end
    pv_hold[i] = v && !r && !ab;
    pv_word[i] = w;
    pv_v[i]    = v;
  endtask

  always @(negedge clk) begin
    mon(0, sa.out_valid, sa.out_ready, sa.out_data, sa.out_sof, sa.out_eol, abort_a);
    mon(1, sb.out_valid, sb.out_ready, sb.out_data, sb.out_sof, sb.out_eol, abort_b);
  end

  function automatic logic rclk_of(input int i);  return (i == 0) ? rclk_a : rclk_b; endfunction
  function automatic logic rrst_of(input int i);  return (i == 0) ? rrst_a : rrst_b; endfunction
  function automatic logic fr_of(input int i);    return (i == 0) ? fr_a : fr_b; endfunction
  function automatic logic valid_of(input int i); return (i == 0) ? sa.out_valid : sb.out_valid; endfunction
  function automatic logic [15:0] fc_of(input int i); return (i == 0) ? fc_a : fc_b; endfunction

  task automatic set_nf(input int i, input logic v);
    if (i == 0) nf_a = v; else nf_b = v;
  endtask

  task automatic reset_vals(input int i);
    chk("rst_rclk", rclk_of(i), 1);
    chk("rst_rrst", rrst_of(i), 1);
    chk("rst_frame_read", fr_of(i), 1);
    chk("rst_valid", valid_of(i), 0);
    chk("rst_sof", (i == 0) ? sa.out_sof : sb.out_sof, 0);
    chk("rst_eol", (i == 0) ? sa.out_eol : sb.out_eol, 0);
    chk("rst_data", (i == 0) ? sa.out_data : sb.out_data, 0);
    chk("rst_frame_count", fc_of(i), 0);
  endtask

  // Raises new_frame for exactly one edge N and traces edges N+1..N+8.
  task automatic start_and_trace(input int i);
    int e_rrst[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int e_rclk[8] = '{1, 0, 1, 0, 0, 1, 0, 0};
    int e_val[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    load_frame(i);
    acc_edge[i] = -1;
    acc_n[i]    = 0;
    if (i == 0) log_a.delete();
    @(posedge clk); #1 set_nf(i, 1'b1);
    @(posedge clk); #1 set_nf(i, 1'b0);
    chk("start_frame_read", fr_of(i), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("seq_rrst", rrst_of(i), e_rrst[k]);
      chk("seq_rclk", rclk_of(i), e_rclk[k]);
      chk("seq_valid", valid_of(i), e_val[k]);
    end
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (fr_of(i)) break;
      @(posedge clk); #1;
    end
    chk("frame_done", fr_of(i), 1);
  endtask

  task automatic wait_byte(input int i, input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (valid_of(i) && acc_n[i] == n) break;
      @(posedge clk); #1;
    end
    chk("byte_reached", valid_of(i) && acc_n[i] == n, 1);
  endtask

  initial begin
    logic [9:0] lit_a[8] = '{10'h210, 10'h111, 10'h00D, 10'h00A,
                              10'h012, 10'h113, 10'h00D, 10'h00A};
    int r0, rb0;
    for (int i = 0; i < 2; i++) begin
      acc_edge[i] = -1; acc_n[i] = 0; pv_hold[i] = 1'b0; pv_v[i] = 1'b0; pv_word[i] = '0;
    end
    sa.out_ready = 1'b1;
    sb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_vals(0);
    reset_vals(1);
    rst_n = 1'b1;

    // Frame on A: literal byte sequence, flags, count and rclk edges.
    r0 = rises_a;
    start_and_trace(0);
    wait_done(0, 200);
    chk("a_frame_count", fc_a, 1);
    chk("a_log_len", log_a.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < log_a.size()) chk("a_literal_byte", {22'b0, log_a[k]}, {22'b0, lit_a[k]});
    chk("a_rclk_rises", rises_a - r0, 5);
    chk("a_queue_drained", q_a.size(), 0);

    // Frame on B with the sink stalled for 10 clocks on the third byte.
    rb0 = rises_b;
    start_and_trace(1);
    wait_byte(1, 2, 200);
    sb.out_ready = 1'b0;
    r0 = rises_b;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_no_rclk", rises_b - r0, 0);
    chk("stall_valid", sb.out_valid, 1);
    chk("stall_no_accept", acc_n[1], 2);
    sb.out_ready = 1'b1;
    wait_done(1, 400);
    chk("b_frame_count", fc_b, 1);
    chk("b_rclk_rises", rises_b - rb0, 13);
    chk("b_bytes", acc_n[1], 14);
    chk("b_queue_drained", q_b.size(), 0);

    // Abort on A while its fifth output byte is presented with ready high.
    start_and_trace(0);
    wait_byte(0, 4, 200);
    abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    chk("abort_valid", sa.out_valid, 0);
    chk("abort_frame_read", fr_a, 1);
    chk("abort_frame_count", fc_a, 1);
    chk("abort_rclk", rclk_a, 1);
    chk("abort_rrst", rrst_a, 1);
    chk("abort_not_counted", acc_n[0], 4);
    q_a.delete();
    start_and_trace(0);
    wait_done(0, 200);
    chk("a_restart_count", fc_a, 2);
    chk("a_restart_drained", q_a.size(), 0);

    // Asynchronous reset in the middle of a B line.
    start_and_trace(1);
    wait_byte(1, 3, 200);
    rst_n = 1'b0;
    #1;
    reset_vals(1);
    chk("rst_a_frame_count", fc_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    q_b.delete();
    rb0 = rises_b;
    start_and_trace(1);
    wait_done(1, 400);
    chk("b_after_rst_count", fc_b, 1);
    chk("b_after_rst_rises", rises_b - rb0, 13);
    chk("b_after_rst_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
